// File: rtl/div_pkg.sv
// Shared types, widths and constants for the sequential signed divider.
package div_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;

  localparam logic [DIV_W-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [DIV_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Unsigned magnitude of a two's complement value; INT_MIN maps to 2^31 exactly.
  function automatic logic [DIV_W-1:0] absMag(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DIV_W-1:0] applySign(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Operand/result bundle for div_seq: start-level launch, one-cycle valid pulse.
interface div_seq_if;

  logic [div_pkg::DIV_W-1:0] dvdnd;
  logic [div_pkg::DIV_W-1:0] dvsor;
  logic                      start;
  logic [div_pkg::DIV_W-1:0] quot;
  logic [div_pkg::DIV_W-1:0] remd;
  logic                      valid;
  logic                      dvz;
  logic                      ovf;

  modport master (
    output dvdnd, dvsor, start,
    input  quot, remd, valid, dvz, ovf
  );

  modport slave (
    input  dvdnd, dvsor, start,
    output quot, remd, valid, dvz, ovf
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0] remIn_i,
  input  logic           bit_i,
  input  logic [DIV_W:0] dvsor_i,
  output logic [DIV_W:0] remOut_o,
  output logic           qBit_o
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W:0]   diff;

  // The compare sees the full shifted value so no carry out of the remainder is lost.
  always_comb begin
    shifted  = {remIn_i, bit_i};
    qBit_o   = (shifted >= {1'b0, dvsor_i});
    diff     = shifted[DIV_W:0] - dvsor_i;
    remOut_o = qBit_o ? diff : shifted[DIV_W:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit signed divider: 32 restoring iterations, fixed 33-cycle latency.
module div_seq
  import div_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  div_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q;
  logic             startDly_q;
  logic [DIV_W-1:0] dvdSh_q;
  logic [DIV_W:0]   dvsMag_q;
  logic [DIV_W:0]   rem_q;
  logic             sq_q, sr_q;
  logic             dvzPend_q, ovfPend_q;
  logic [DIV_W-1:0] dvdOrig_q;
  logic [DIV_W-1:0] quot_q, remd_q;
  logic             valid_q, dvz_q, ovf_q;

  logic             launch, stepEn, lastIter;
  logic [DIV_W:0]   remNext;
  logic             qBit;
  logic [DIV_W-1:0] qRaw, resQuot, resRemd;

  div_step u_step (
    .remIn_i  (rem_q),
    .bit_i    (dvdSh_q[DIV_W-1]),
    .dvsor_i  (dvsMag_q),
    .remOut_o (remNext),
    .qBit_o   (qBit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch)   state_d = RUN;
      RUN:     if (lastIter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch   = (state_q == IDLE) && bus.start && !startDly_q;
    stepEn   = (state_q == RUN);
    lastIter = stepEn && (cnt_q == 5'(DIV_ITER-1));
  end

  // Quotient bits enter the dividend shift register as dividend bits leave it.
  always_comb begin
    qRaw    = {dvdSh_q[DIV_W-2:0], qBit};
    resQuot = applySign(sq_q, qRaw);
    resRemd = applySign(sr_q, remNext[DIV_W-1:0]);
    if (dvzPend_q) begin
      resQuot = ALL_ONES;
      resRemd = dvdOrig_q;
    end else if (ovfPend_q) begin
      resQuot = INT_MIN;
      resRemd = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      startDly_q <= 1'b0;
      dvdSh_q    <= '0;
      dvsMag_q   <= '0;
      rem_q      <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      dvzPend_q  <= 1'b0;
      ovfPend_q  <= 1'b0;
      dvdOrig_q  <= '0;
      quot_q     <= '0;
      remd_q     <= '0;
      valid_q    <= 1'b0;
      dvz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      startDly_q <= bus.start;
      valid_q    <= lastIter;
      if (launch) begin
        cnt_q     <= '0;
        dvdSh_q   <= absMag(bus.dvdnd);
        dvsMag_q  <= {1'b0, absMag(bus.dvsor)};
        rem_q     <= '0;
        sq_q      <= bus.dvdnd[DIV_W-1] ^ bus.dvsor[DIV_W-1];
        sr_q      <= bus.dvdnd[DIV_W-1];
        dvzPend_q <= (bus.dvsor == '0);
        ovfPend_q <= (bus.dvdnd == INT_MIN) && (bus.dvsor == ALL_ONES);
        dvdOrig_q <= bus.dvdnd;
      end else if (stepEn) begin
        cnt_q   <= cnt_q + 5'd1;
        dvdSh_q <= qRaw;
        rem_q   <= remNext;
      end
      if (lastIter) begin
        quot_q <= resQuot;
        remd_q <= resRemd;
        dvz_q  <= dvzPend_q;
        ovf_q  <= ovfPend_q;
      end
    end
  end

  assign bus.quot  = quot_q;
  assign bus.remd  = remd_q;
  assign bus.valid = valid_q;
  assign bus.dvz   = dvz_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit signed integer divider, the inverse companion of the team's sequential multipliers. It takes a dividend and a divisor on a start rising edge, runs one radix-2 restoring iteration per clock, and returns the quotient and remainder with a one-cycle valid pulse. It uses the same start-level / valid-pulse handshake and the same 33-cycle latency budget as the multipliers, so the existing bench style drives it unchanged. It sits beside `multi` and `multi_vl` in the arithmetic datapath.

## Interface
- WIDTH, 32, operand width; only 32 is verified.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- dvdnd  in  WIDTH  signed dividend, two's complement; sampled on launch.
- dvsor  in  WIDTH  signed divisor, two's complement; sampled on launch.
- start  in  1  level input; a rising edge seen while IDLE launches a division.
- quot  out  WIDTH  signed quotient, truncated toward zero.
- remd  out  WIDTH  signed remainder; takes the dividend's sign.
- valid  out  1  one-cycle pulse; quot, remd and flags are valid in that cycle.
- dvz  out  1  divide-by-zero flag; qualified by valid.
- ovf  out  1  overflow flag (-2^31 / -1); qualified by valid.

## Operation
- The block registers start_d <= start; start_d resets to 0. A launch occurs when start && !start_d at a rising edge and the state is IDLE.
  - A start already high when reset deasserts counts as a rising edge.
- States:
  - IDLE: no division in progress.
  - RUN: a 5-bit iteration counter cnt counts 0..31.
  - IDLE follows RUN when the last iteration completes.
- Transitions:
  - IDLE -> RUN on launch.
  - RUN -> IDLE at the edge where cnt==31; valid is set at that same edge.
- On launch the block:
  - latches the magnitudes |dvdnd| and |dvsor| (33-bit internally, so -2^31 is exact);
  - latches the signs: sq = dvdnd[31]^dvsor[31], sr = dvdnd[31];
  - clears the partial remainder;
  - sets dvz = (dvsor==0) and ovf = (dvdnd==0x80000000 && dvsor==0xFFFFFFFF) into pending registers.
- Each RUN edge performs one iteration:
  - shift the partial remainder left and bring in the next dividend MSB;
  - trial-subtract the divisor; keep the difference if it is non-negative and shift 1 into the quotient, else keep the shifted value and shift 0.
- Result correction is applied in the final edge into the output registers:
  - quot = sq ? -Q : Q; remd = sr ? -R : R.
  - dvz case: quot = 0xFFFFFFFF, remd = dvdnd, dvz = 1.
  - ovf case: quot = 0x80000000, remd = 0, ovf = 1.
  - A zero magnitude result is never negated into a nonzero value.
- quot, remd, dvz and ovf hold their values until the next result is written.
- A start rising edge during RUN is ignored and not queued. A start level held high through completion does not relaunch.
- Reset mid-RUN: returns to IDLE, no valid is produced, and all outputs are cleared.

## Timing
- Reset values: quot=0, remd=0, valid=0, dvz=0, ovf=0, state=IDLE, cnt=0, start_d=0.
- Latency: launch at edge N; iterations at edges N+1..N+32; valid is high between edges N+32 and N+33. A consumer counting from the launch edge sees latency 33.
- Latency is fixed for all operands, including the dvz and ovf cases.
- valid is exactly one cycle wide. The earliest next launch is edge N+33, provided start has fallen and risen again.
- Operands need only be stable at the launch edge.

## Structure
- Package div_pkg holds:
  - DIV_W = 32 and DIV_ITER = 32;
  - the state enum {IDLE, RUN};
  - constants INT_MIN = 32'h80000000 and ALL_ONES = 32'hFFFFFFFF.
- Sub-module div_step: a combinational single iteration, taking the partial remainder, the next dividend bit and the divisor, and returning the next partial remainder and the quotient bit. The top module instantiates it once.
- The top module holds the FSM, counter, sign/magnitude registers, correction logic and output registers.

## Test plan
- Basic sign cases, each giving valid exactly 33 cycles after launch:
  - dvdnd=7, dvsor=2 -> quot=3, remd=1, dvz=0, ovf=0.
  - dvdnd=-7 (0xFFFFFFF9), dvsor=2 -> quot=0xFFFFFFFD, remd=0xFFFFFFFF.
  - dvdnd=7, dvsor=-2 -> quot=0xFFFFFFFD, remd=1.
- Extremes:
  - 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, remd=0, ovf=1.
  - 0x80000000 / 1 -> quot=0x80000000, remd=0, ovf=0.
  - 0x7FFFFFFF / 0x7FFFFFFF -> quot=1, remd=0.
- Divide by zero: 0x12345678 / 0 -> quot=0xFFFFFFFF, remd=0x12345678, dvz=1, latency still 33.
- Handshake:
  - Start held high for 33 cycles, then low for 5 cycles, repeated for 28 patterns -> exactly one valid per pattern, outputs held between pulses.
  - A start toggle during RUN produces no extra valid.
- Reset mid-operation: launch 100/7, assert reset at cycle 10 -> outputs 0 and no valid. A relaunch after reset returns quot=14, remd=2.
- Self-check: compare against a behavioural truncating divide over 1000 random operand pairs. Fail if any valid-to-valid latency exceeds 33 or any result mismatches.
